// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: operand forwarding, Val2 shifter, ALU, branch target, NZCV register
// Optional macro EXE_FORWARDING_EN enables the sel_src*/fwd_* operand muxes.
module exe_stage #(
  parameter int         DATA_W     = 32,
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [3:0]        exe_cmd,
  input  logic              s_in,
  input  logic              b_in,
  input  logic              imm_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] fwd_mem_val,
  input  logic [DATA_W-1:0] fwd_wb_val,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_val,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status_out,
  output logic              carry_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]        r_status;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_m;
  logic [DATA_W-1:0] w_val2;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W:0]   w_sum;
  logic              w_c;
  logic              w_v;
  logic [2*DATA_W-1:0] w_imm_rot;
  logic [2*DATA_W-1:0] w_reg_ror;
  logic [4:0]        w_shamt;

`ifdef EXE_FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   w_op_a = fwd_mem_val;
      2'b10:   w_op_a = fwd_wb_val;
      default: w_op_a = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_op_m = fwd_mem_val;
      2'b10:   w_op_m = fwd_wb_val;
      default: w_op_m = val_rm_in;
    endcase
  end
`else
  // The hazard unit stalls instead of forwarding, so these inputs are dead here.
  logic w_fwd_unused;
  assign w_fwd_unused = ^{sel_src1, sel_src2, fwd_mem_val, fwd_wb_val};
  assign w_op_a = val_rn_in;
  assign w_op_m = val_rm_in;
`endif

  assign store_val = w_op_m;

  // Rotates are taken from a doubled word so a zero amount passes the value through.
  assign w_shamt   = shift_operand_in[11:7];
  assign w_imm_rot = {{24'b0, shift_operand_in[7:0]}, {24'b0, shift_operand_in[7:0]}}
                     >> {shift_operand_in[11:8], 1'b0};
  assign w_reg_ror = {w_op_m, w_op_m} >> w_shamt;

  always_comb begin
    w_val2 = w_op_m;
    if (mem_r_en_in || mem_w_en_in) begin
      w_val2 = {20'b0, shift_operand_in};
    end else if (imm_in) begin
      w_val2 = w_imm_rot[DATA_W-1:0];
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   w_val2 = w_op_m << w_shamt;
        2'b01:   w_val2 = w_op_m >> w_shamt;
        2'b10:   w_val2 = $signed(w_op_m) >>> w_shamt;
        default: w_val2 = w_reg_ror[DATA_W-1:0];
      endcase
    end
  end

  // Subtraction is A + ~Val2 + carry-in, so C comes out as NOT borrow.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = r_status[1];
    w_v   = r_status[0];
    case (exe_cmd)
      CMD_MOV: w_res = w_val2;
      CMD_MVN: w_res = ~w_val2;
      CMD_ADD, CMD_ADC: begin
        w_sum = {1'b0, w_op_a} + {1'b0, w_val2}
              + {{DATA_W{1'b0}}, (exe_cmd == CMD_ADC) & r_status[1]};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_op_a[DATA_W-1] == w_val2[DATA_W-1]) && (w_res[DATA_W-1] != w_op_a[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        w_sum = {1'b0, w_op_a} + {1'b0, ~w_val2}
              + {{DATA_W{1'b0}}, (exe_cmd == CMD_SUB) | r_status[1]};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_op_a[DATA_W-1] != w_val2[DATA_W-1]) && (w_res[DATA_W-1] != w_op_a[DATA_W-1]);
      end
      CMD_AND: w_res = w_op_a & w_val2;
      CMD_ORR: w_res = w_op_a | w_val2;
      CMD_EOR: w_res = w_op_a ^ w_val2;
      default: w_res = '0;
    endcase
  end

  assign alu_result = w_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= STATUS_RST;
    end else if (s_in && !freeze) begin
      r_status <= {w_res[DATA_W-1], w_res == '0, w_c, w_v};
    end
  end

  assign status_out   = r_status;
  assign carry_out    = r_status[1];
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline, directly downstream of the ID/EX pipeline register. Consumes the registered decode outputs.
- Selects operands through the forwarding muxes, generates Val2, and computes the ALU result and the branch target.
- Owns the NZCV status register and feeds it back to the ID stage for condition evaluation.
- Outputs go to the EX/MEM register and the hazard/fetch logic.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
STATUS_RST, 4'b0000, NZCV value loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
freeze  input  1  pipeline stall; blocks status update
exe_cmd  input  4  ALU command from ID/EX
s_in  input  1  update status flags
b_in  input  1  branch instruction
imm_in  input  1  immediate operand form
mem_r_en_in  input  1  load instruction
mem_w_en_in  input  1  store instruction
pc_in  input  32  PC+4 of this instruction
val_rn_in  input  32  Rn value from register file
val_rm_in  input  32  Rm value from register file
signed_imm_24_in  input  24  branch offset, in words
shift_operand_in  input  12  shifter operand field
sel_src1  input  2  Rn forward select: 00 ID, 01 MEM, 10 WB, 11 ID
sel_src2  input  2  Rm forward select, same encoding
fwd_mem_val  input  32  ALU result currently in the MEM stage
fwd_wb_val  input  32  write-back value
alu_result  output  32  ALU result or memory address
store_val  output  32  forwarded Rm, used as store data
branch_taken  output  1  equals b_in
branch_addr  output  32  branch target
status_out  output  4  registered {N,Z,C,V}
carry_out  output  1  registered C, equal to status_out[1]

Behaviour:
- Reset: status register takes STATUS_RST immediately and asynchronously. All other outputs are combinational functions of the inputs and the status register.
- Latency: alu_result, store_val, branch_* are combinational (0 cycles). status_out changes on the clk edge following a flag-setting instruction.
- Operand A = mux(sel_src1: val_rn_in, fwd_mem_val, fwd_wb_val). Operand Rm' = mux(sel_src2: val_rm_in, fwd_mem_val, fwd_wb_val). store_val = Rm'.
- Val2 priority:
  1. mem_r_en_in|mem_w_en_in: zero-extended shift_operand_in[11:0].
  2. imm_in: {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
  3. Otherwise Rm' shifted by shift_operand_in[11:7] with type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm' unchanged for all types.
- exe_cmd, with C = registered carry:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: A+Val2
  - 0011 ADC: A+Val2+C
  - 0100 SUB: A-Val2
  - 0101 SBC: A-Val2-!C
  - 0110 AND: A&Val2
  - 0111 ORR: A|Val2
  - 1000 EOR: A^Val2
  - Others: result 0, flags C/V held.
- Loads and stores arrive with exe_cmd=0010, giving the address A+offset.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = 33rd-bit carry out, with subtract C = NOT borrow (ARM). V = signed overflow of A op Val2.
  - Logical and move ops: C and V keep their registered values.
- Status update: on rising clk when s_in=1 and freeze=0, status ← {N,Z,C,V}. When s_in=0 or freeze=1 it holds. Flushed bubbles arrive with s_in=0 and do not update.
- branch_addr = pc_in + {{6{imm24[23]}}, imm24, 2'b00}, with wrap-around modulo 2^32. branch_taken = b_in; condition gating is done in ID.
- Reset mid-instruction: the status register clears regardless of s_in or freeze. The combinational path is unaffected.

Optional Feature:
- Macro: EXE_FORWARDING_EN.
- Defined: sel_src1 and sel_src2 act as specified above.
- Undefined: the sel_* and fwd_* ports remain present but are ignored. A = val_rn_in, Rm' = val_rm_in, and no mux logic is synthesised. The hazard unit stalls in this configuration.

Test Plan:
- rst=1 during a flag-setting op -> status_out=STATUS_RST, carry_out=0; release rst, then ADDS 0xFFFFFFFF+1 with s_in=1 -> alu_result=0, status_out=4'b0110 after the edge.
- SUBS A=5, imm Val2=5 -> result 0, NZCV=0110. Then SUBS A=3, Val2=5 -> 0xFFFFFFFE, NZCV=1000.
- ADDS 0x7FFFFFFF+1 -> 0x80000000, NZCV=1001. Same op with freeze=1 -> status_out unchanged.
- Immediate rotate: shift_operand=0x4FF -> Val2=0xFF000000. Register ASR: Rm=0x80000000, shift 0x2C0 (ASR by 5) -> 0xFC000000. STR: shift_operand=0xABC, A=0x100 -> alu_result=0xBBC.
- Forwarding (macro defined): sel_src1=01, fwd_mem_val=7, val_rn_in=1, ADD Val2=1 -> 8. Same stimulus with the macro undefined -> 2.
- Branch: pc_in=0x100, imm24=0xFFFFFE -> branch_addr=0xF8, branch_taken=1. ADC with C=1: 2+3 -> 6.
